// File: rtl/cla_pkg.sv
// Shared types and widths for the 12-bit carry-lookahead adder/subtractor family.
package cla_pkg;

   localparam int DATA_W = 12;
   localparam int SEG_W  = 6;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [SEG_W-1:0]  seg_t;

endpackage

// File: rtl/cla6.sv
// Combinational 6-bit carry-lookahead adder segment: s = x + y + cin, with carry out.
module cla6
   import cla_pkg::*;
(
   input  seg_t x,
   input  seg_t y,
   input  logic cin,
   output seg_t s,
   output logic cout
);

   seg_t             w_g;
   seg_t             w_p;
   logic [SEG_W:0]   w_c;

   assign w_g = x & y;
   assign w_p = x ^ y;

   // Each carry is the OR of every lower generate whose path up to here fully propagates.
   always_comb begin
      logic w_acc;
      logic w_run;
      w_acc  = 1'b0;
      w_run  = 1'b0;
      w_c    = '0;
      w_c[0] = cin;
      for (int i = 0; i < SEG_W; i++) begin
         w_acc = 1'b0;
         w_run = 1'b1;
         for (int j = i; j >= 0; j--) begin
            w_acc = w_acc | (w_g[j] & w_run);
            w_run = w_run & w_p[j];
         end
         w_c[i+1] = w_acc | (w_run & cin);
      end
   end

   assign s    = w_p ^ w_c[SEG_W-1:0];
   assign cout = w_c[SEG_W];

endmodule

// File: rtl/cla_sub12_pipe.sv
// Two-stage pipelined 12-bit subtractor (a - b - bin) built from two cla6 segments,
// with valid/ready handshakes, borrow out and signed overflow.
module cla_sub12_pipe #(
   parameter int WIDTH = 12,
   parameter int SEG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   import cla_pkg::*;

   localparam int HI_W = WIDTH - SEG_W;

   logic             r_s1Valid;
   logic [SEG_W-1:0] r_loDiff;
   logic             r_c6;
   logic [HI_W-1:0]  r_aHi;
   logic [HI_W-1:0]  r_nbHi;
   logic             r_aMsb;
   logic             r_bMsb;

   logic             r_s2Valid;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_ovf;

   logic             w_s1Accept;
   logic             w_s2Accept;
   logic [SEG_W-1:0] w_nbLo;
   logic [SEG_W-1:0] w_loSum;
   logic             w_c6;
   logic [HI_W-1:0]  w_hiSum;
   logic             w_c12;

   // in_ready follows out_ready combinationally so a full pipe can still take a beat while draining.
   assign w_s2Accept = !r_s2Valid || out_ready;
   assign w_s1Accept = !r_s1Valid || w_s2Accept;
   assign in_ready   = w_s1Accept;

   assign w_nbLo = ~b[SEG_W-1:0];

   cla6 u_claLo (
      .x    (a[SEG_W-1:0]),
      .y    (w_nbLo),
      .cin  (~bin),
      .s    (w_loSum),
      .cout (w_c6)
   );

   cla6 u_claHi (
      .x    (r_aHi),
      .y    (r_nbHi),
      .cin  (r_c6),
      .s    (w_hiSum),
      .cout (w_c12)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_loDiff  <= '0;
         r_c6      <= 1'b0;
         r_aHi     <= '0;
         r_nbHi    <= '0;
         r_aMsb    <= 1'b0;
         r_bMsb    <= 1'b0;
      end else if (w_s1Accept) begin
         r_s1Valid <= in_valid;
         if (in_valid) begin
            r_loDiff <= w_loSum;
            r_c6     <= w_c6;
            r_aHi    <= a[WIDTH-1:SEG_W];
            r_nbHi   <= ~b[WIDTH-1:SEG_W];
            r_aMsb   <= a[WIDTH-1];
            r_bMsb   <= b[WIDTH-1];
         end
      end
   end

   // Overflow: operands of opposite sign and the result sign differs from the minuend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2Valid <= 1'b0;
         r_d       <= '0;
         r_bout    <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (w_s2Accept) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_d    <= {w_hiSum, r_loDiff};
            r_bout <= ~w_c12;
            r_ovf  <= (r_aMsb != r_bMsb) && (w_hiSum[HI_W-1] != r_aMsb);
         end
      end
   end

   assign out_valid = r_s2Valid;
   assign d         = r_d;
   assign bout      = r_bout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_sub12_pipe.sv
// Scoreboard bench for cla_sub12_pipe: expectations are queued on input accept
// and compared in order whenever a result beat is consumed.
module tb_cla_sub12_pipe;

   import cla_pkg::*;

   typedef struct packed {
      logic [11:0] d;
      logic        bout;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] a;
   logic [11:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] d;
   logic        bout;
   logic        ovf;

   exp_t        sbQ[$];
   int          numChecks;
   int          numFails;
   logic        randReady;

   logic        holdValid;
   logic [11:0] holdD;
   logic        holdBout;
   logic        holdOvf;

   cla_sub12_pipe #(.WIDTH(12), .SEG_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t modelSub(input logic [11:0] ma, input logic [11:0] mb, input logic mbin);
      logic [12:0] full;
      exp_t        e;
      full   = {1'b0, ma} - {1'b0, mb} - {12'b0, mbin};
      e.d    = full[11:0];
      e.bout = full[12];
      e.ovf  = (ma[11] != mb[11]) && (full[11] != ma[11]);
      return e;
   endfunction

   // Offers one beat, queues its expectation on the accepting edge, then withdraws it.
   task automatic applyStimulus(input logic [11:0] va, input logic [11:0] vb, input logic vbin);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      bin      = vbin;
      for (int k = 0; k < 200 && !accepted; k++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1'b1;
            sbQ.push_back(modelSub(va, vb, vbin));
         end
      end
      if (!accepted) checkOutput("acceptTimeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      if (randReady) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Output monitor: stall stability and in-order scoreboard comparison.
   always @(negedge clk) begin
      if (!rst_n) begin
         holdValid = 1'b0;
      end else begin
         if (holdValid) begin
            checkOutput("holdValid", {31'b0, out_valid}, 32'd1);
            checkOutput("holdD", {20'b0, d}, {20'b0, holdD});
            checkOutput("holdBout", {31'b0, bout}, {31'b0, holdBout});
            checkOutput("holdOvf", {31'b0, ovf}, {31'b0, holdOvf});
         end
         if (out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpectedBeat", {31'b0, out_valid}, 32'd0);
            end else begin
               exp_t e;
               e = sbQ.pop_front();
               checkOutput("resD", {20'b0, d}, {20'b0, e.d});
               checkOutput("resBout", {31'b0, bout}, {31'b0, e.bout});
               checkOutput("resOvf", {31'b0, ovf}, {31'b0, e.ovf});
            end
         end
         holdValid = out_valid && !out_ready;
         holdD     = d;
         holdBout  = bout;
         holdOvf   = ovf;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: simulation did not finish, got running expected done");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      numChecks = 0;
      numFails  = 0;
      randReady = 1'b0;
      holdValid = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
      checkOutput("rstD", {20'b0, d}, 32'd0);
      checkOutput("rstBout", {31'b0, bout}, 32'd0);
      checkOutput("rstOvf", {31'b0, ovf}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Result appears one edge after the stage-1 load edge, i.e. two cycles after offer.
      applyStimulus(12'd28, 12'd12, 1'b0);
      checkOutput("latencyEarly", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("latencyValid", {31'b0, out_valid}, 32'd1);
      checkOutput("latencyD", {20'b0, d}, 32'h010);

      applyStimulus(12'hFE1, 12'hFD3, 1'b0);
      applyStimulus(12'h000, 12'h001, 1'b0);
      applyStimulus(12'h800, 12'h001, 1'b0);
      applyStimulus(12'h040, 12'h001, 1'b0);
      applyStimulus(12'd5,   12'd3,   1'b1);
      applyStimulus(12'h123, 12'h123, 1'b1);
      applyStimulus(12'h7FF, 12'hFFF, 1'b0);
      repeat (4) @(posedge clk);
      #1;

      // Fill both stages while the consumer stalls; the third beat must be refused.
      out_ready = 1'b0;
      applyStimulus(12'd10, 12'd1, 1'b0);
      applyStimulus(12'd20, 12'd2, 1'b0);
      in_valid = 1'b1;
      a        = 12'd30;
      b        = 12'd3;
      bin      = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checkOutput("fullInReady", {31'b0, in_ready}, 32'd0);
         checkOutput("stallValid", {31'b0, out_valid}, 32'd1);
         checkOutput("stallD", {20'b0, d}, 32'd9);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(12'd30, 12'd3, 1'b0);
      repeat (4) @(posedge clk);
      #1;

      // Reset with both stages occupied discards everything in flight.
      out_ready = 1'b0;
      applyStimulus(12'h111, 12'h001, 1'b0);
      applyStimulus(12'h222, 12'h002, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", {31'b0, out_valid}, 32'd0);
      checkOutput("midRstD", {20'b0, d}, 32'd0);
      sbQ.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("noStaleBeat", {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(12'd7, 12'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      randReady = 1'b1;
      for (int n = 0; n < 40; n++) begin
         applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                       1'($urandom_range(0, 1)));
      end
      randReady = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      for (int k = 0; k < 50 && sbQ.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      checkOutput("drainEmpty", sbQ.size(), 32'd0);
      checkOutput("drainIdle", {31'b0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/cla_sub12_pipe.md
Name: cla_sub12_pipe

Overview:
Two-stage pipelined 12-bit subtractor with borrow in/out and a signed overflow flag. It is the inverse-direction companion of the team's 12-bit carry-lookahead adder (operands x, y, carry c, sum s, carry-out c12). It computes a - b - bin as a + ~b + ~bin, using two 6-bit carry-lookahead segments split across pipeline registers. Valid/ready handshakes on both sides let it sit between an operand source and a result consumer that may stall.

Parameters:
WIDTH, 12, operand/result width; must equal 2*SEG_W.
SEG_W, 6, width of each carry-lookahead segment; one segment per pipeline stage.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat offered
in_ready  output  1  block accepts operand beat this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in (1 = subtract one more)
out_valid  output  1  result beat offered
out_ready  input  1  consumer accepts result this cycle
d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH
bout  output  1  borrow out = NOT carry-out of a + ~b + ~bin (unsigned a < b + bin)
ovf  output  1  signed two's-complement overflow

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, async): s1_valid = 0, s2_valid = 0, out_valid = 0, d = 0, bout = 0, ovf = 0. in_ready is 1 once reset is released.
- Reset mid-operation: all in-flight beats are discarded. No output beat appears after rst_n rises until a new operand is accepted.
- Handshake rule: a transfer occurs when valid && ready on the same rising edge. in_ready and out_ready are never required to wait on valid.
- Output stability: out_valid, d, bout and ovf hold stable while out_valid && !out_ready.
- Stage 1, on input accept:
  - Low segment: a[5:0] + ~b[5:0] + ~bin through a cla6 instance.
  - Registers the low difference, the segment carry c6, a[11:6], ~b[11:6], a[11] and b[11].
- Stage 2, on advance:
  - High segment: a_hi + nb_hi + c6 through a second cla6 instance.
  - Registers d = {hi_sum, lo_diff}.
  - bout = ~c12.
  - ovf = (a[11] != b[11]) && (d[11] != a[11]).
- Advance conditions:
  - s2_accept = !s2_valid || out_ready.
  - s1_accept = !s1_valid || s2_accept.
  - in_ready = s1_accept. This is a combinational path from out_ready; the path is intentional.
- Latency: 2 cycles from the input-accept edge to out_valid, when there is no stall.
- Throughput: 1 beat per cycle while out_ready is held high.
- Full condition: both stages valid and out_ready low -> in_ready = 0; nothing is overwritten or dropped.
- Simultaneous events: in the same cycle, the output is consumed, stage 1 moves to stage 2, and a new operand enters stage 1. No bubble is inserted.
- Ordering: results leave in strict input order.
- Arithmetic:
  - All arithmetic is unsigned modulo 2^12.
  - A borrow across the segment boundary is carried exactly through c6.
  - bin = 1 with a = b gives d = 0xFFF and bout = 1.
- No state machine beyond the two valid bits; no counters.

Decomposition:
- Package cla_pkg:
  - localparams DATA_W = 12 and SEG_W = 6.
  - typedef logic [DATA_W-1:0] word_t.
  - typedef logic [SEG_W-1:0] seg_t.
  - Shared with the existing adder.
- Sub-module cla6 (purely combinational):
  - Inputs x, y (seg_t) and cin.
  - Outputs s (seg_t) and cout.
  - Generate/propagate lookahead over 6 bits.
  - Instantiated twice, once per stage.

Test Plan:
- a=28, b=12, bin=0, out_ready=1 -> after 2 cycles d=16 (0x010), bout=0, ovf=0.
- a=-31 (0xFE1), b=-45 (0xFD3), bin=0 -> d=14 (0x00E), bout=0, ovf=0.
- a=0x000, b=0x001 -> d=0xFFF, bout=1, ovf=0.
- a=0x800, b=0x001 -> d=0x7FF, bout=0, ovf=1.
- a=0x040, b=0x001 (segment-boundary borrow) -> d=0x03F.
- a=5, b=3, bin=1 -> d=1, bout=0.
- Back-to-back inputs 10-1, 20-2, 30-3 while out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts.
  - Once out_ready=1: outputs 9, 18, 27 in order, each held stable while stalled.
- rst_n pulsed low with both stages valid -> out_valid=0 immediately, d=0.
- After release, no stale beat appears; next input a=7, b=7 -> d=0, bout=0.
